// File: rtl/dsp_intr_pkg.sv
// -----------------------------------------------------------------------------
// dsp_intr_pkg
// Shared types and constants for the DSP XINTF interrupt monitor.
//   state_t        : monitor FSM state encoding (2 bits, exposed on o_state)
//   *_DEF          : default parameter values for dsp_intr_monitor
//   CNT_W          : width of the period counter / o_period
//   sat_inc()      : saturating increment of a CNT_W-bit counter value
// -----------------------------------------------------------------------------
package dsp_intr_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        RUN        = 2'd2,
        FAULT      = 2'd3
    } state_t;

    localparam int PERIOD_NOM_DEF = 1000;
    localparam int TOL_DEF        = 50;
    localparam int TIMEOUT_DEF    = 2000;
    localparam int FILT_DEF       = 4;

    localparam int CNT_W = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/dsp_intr_sync_edge.sv
// -----------------------------------------------------------------------------
// dsp_intr_sync_edge
// Brings the asynchronous DSP interrupt into the i_clk domain and produces a
// one-cycle strobe for each accepted rising edge.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_intr       : raw asynchronous interrupt
//   o_edge       : combinational one-cycle strobe, high when an edge is accepted
// Optional feature: DSP_INTR_GLITCH_FILTER_EN enables a filter that accepts a
// rising edge only after P_FILT consecutive high synchronised samples.
// Without it the edge is simply "synchronised high, previous sample low".
// -----------------------------------------------------------------------------
module dsp_intr_sync_edge #(
    parameter int P_FILT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_intr,
    output logic o_edge
);

    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_intr;
            r_sync2 <= r_sync1;
        end
    end

`ifdef DSP_INTR_GLITCH_FILTER_EN
    localparam int LP_HW = $clog2(P_FILT + 1);
    localparam logic [LP_HW-1:0] LP_FILT    = LP_HW'(P_FILT);
    localparam logic [LP_HW-1:0] LP_FILT_M1 = LP_HW'(P_FILT - 1);

    // Run length of consecutive high samples; parks at P_FILT so a long high
    // level fires exactly once and only a low sample re-arms the filter.
    logic [LP_HW-1:0] r_hcnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hcnt <= '0;
        end else if (!r_sync2) begin
            r_hcnt <= '0;
        end else if (r_hcnt != LP_FILT) begin
            r_hcnt <= r_hcnt + 1'b1;
        end
    end

    // Fires on the P_FILT-th high sample in a row.
    assign o_edge = r_sync2 && (r_hcnt == LP_FILT_M1);
`else
    logic r_prev;
    logic w_unused_filt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= r_sync2;
        end
    end

    assign o_edge        = r_sync2 && !r_prev;
    assign w_unused_filt = ^P_FILT;
`endif

endmodule

// File: rtl/dsp_intr_monitor.sv
// -----------------------------------------------------------------------------
// dsp_intr_monitor
// Conditions the DSP XINTF interrupt: synchronises it, turns each rising edge
// into a one-cycle start pulse for the XINTF FSM, measures the interval
// between edges and raises sticky early / timeout faults.
// Ports:
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_DSP_intr        : raw asynchronous DSP interrupt
//   i_enable          : monitor enable (0 forces IDLE, flags retained)
//   i_clr             : one-cycle clear of the sticky flags
//   o_intr_pulse      : one-cycle start pulse
//   o_period          : last measured period in clocks
//   o_period_valid    : one-cycle strobe when o_period updates
//   o_intr_count      : accepted-edge count (wraps)
//   o_early           : sticky, a period was shorter than P_PERIOD_NOM-P_TOL
//   o_timeout         : sticky, no edge within P_TIMEOUT clocks in RUN
//   o_state           : FSM state (IDLE/WAIT_FIRST/RUN/FAULT) for debug
// Strobe semantics: o_intr_pulse and o_period_valid are single-cycle strobes
// with no back-pressure; the consumer must sample them in the cycle they are
// high. o_period, o_early and o_intr_count change in that same cycle.
// Optional feature: DSP_INTR_GLITCH_FILTER_EN (see dsp_intr_sync_edge).
// -----------------------------------------------------------------------------
module dsp_intr_monitor
    import dsp_intr_pkg::*;
#(
    parameter int P_PERIOD_NOM = PERIOD_NOM_DEF,
    parameter int P_TOL        = TOL_DEF,
    parameter int P_TIMEOUT    = TIMEOUT_DEF,
    parameter int P_FILT       = FILT_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_DSP_intr,
    input  logic              i_enable,
    input  logic              i_clr,
    output logic              o_intr_pulse,
    output logic [CNT_W-1:0]  o_period,
    output logic              o_period_valid,
    output logic [31:0]       o_intr_count,
    output logic              o_early,
    output logic              o_timeout,
    output logic [1:0]        o_state
);

    localparam logic [CNT_W-1:0] LP_EARLY = CNT_W'(P_PERIOD_NOM - P_TOL);
    localparam logic [CNT_W-1:0] LP_TO    = CNT_W'(P_TIMEOUT);
    localparam logic [CNT_W-1:0] LP_TO_M1 = CNT_W'(P_TIMEOUT - 1);

    logic             w_edge;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_pulse;
    logic             w_latch;
    logic             w_cnt_clr;
    logic             w_set_to;
    logic             w_set_early;
    logic             r_pulse;
    logic             r_pvalid;
    logic [CNT_W-1:0] r_period;
    logic [31:0]      r_count;
    logic             r_early;
    logic             r_timeout;

    dsp_intr_sync_edge #(
        .P_FILT (P_FILT)
    ) u_sync_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_intr (i_DSP_intr),
        .o_edge (w_edge)
    );

    assign w_cnt_inc = sat_inc(r_cnt);

    always_comb begin
        w_state_nxt = r_state;
        w_pulse     = 1'b0;
        w_latch     = 1'b0;
        w_cnt_clr   = 1'b0;
        w_set_to    = 1'b0;
        if (!i_enable) begin
            w_state_nxt = IDLE;
            w_cnt_clr   = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = WAIT_FIRST;
                    w_cnt_clr   = 1'b1;
                end
                WAIT_FIRST: begin
                    if (w_edge) begin
                        w_pulse     = 1'b1;
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (w_edge) begin
                        w_pulse   = 1'b1;
                        w_latch   = 1'b1;
                        w_cnt_clr = 1'b1;
                    end else begin
                        // o_timeout rises with the counter reaching P_TIMEOUT;
                        // the state follows one cycle later. An edge in either
                        // of those cycles takes priority.
                        if (r_cnt == LP_TO_M1) begin
                            w_set_to = 1'b1;
                        end
                        if (r_cnt == LP_TO) begin
                            w_state_nxt = FAULT;
                        end
                    end
                end
                FAULT: begin
                    if (w_edge) begin
                        w_pulse     = 1'b1;
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = RUN;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_clr   = 1'b1;
                end
            endcase
        end
    end

    // The period reported for an edge counts the edge cycle itself, so edges
    // N clocks apart report N.
    assign w_set_early = w_latch && (w_cnt_inc < LP_EARLY);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_pulse   <= 1'b0;
            r_pvalid  <= 1'b0;
            r_period  <= '0;
            r_count   <= '0;
            r_early   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_pulse  <= w_pulse;
            r_pvalid <= w_latch;
            if (w_cnt_clr || (r_state == IDLE)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_inc;
            end
            if (w_latch) begin
                r_period <= w_cnt_inc;
            end
            if (w_pulse) begin
                r_count <= r_count + 32'd1;
            end
            // A flag being set in the same cycle as i_clr stays set.
            if (w_set_early) begin
                r_early <= 1'b1;
            end else if (i_clr) begin
                r_early <= 1'b0;
            end
            if (w_set_to) begin
                r_timeout <= 1'b1;
            end else if (i_clr) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign o_intr_pulse   = r_pulse;
    assign o_period_valid = r_pvalid;
    assign o_period       = r_period;
    assign o_intr_count   = r_count;
    assign o_early        = r_early;
    assign o_timeout      = r_timeout;
    assign o_state        = r_state;

endmodule

// File: tb/tb_dsp_intr_monitor.sv
module tb_dsp_intr_monitor;
  import dsp_intr_pkg::*;

`ifdef DSP_INTR_GLITCH_FILTER_EN
  localparam int LAT = 3 + FILT_DEF - 1;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dsp_intr = 1'b0;
  logic        enable = 1'b0;
  logic        clr = 1'b0;
  logic        intr_pulse;
  logic [15:0] period;
  logic        period_valid;
  logic [31:0] intr_count;
  logic        early;
  logic        timeout;
  logic [1:0]  state;

  int errors = 0;
  int checks = 0;
  int since_raise = 100000;
  int n_pulse = 0;
  int n_valid = 0;
  logic [31:0] exp_count = 32'd0;

  dsp_intr_monitor dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_DSP_intr     (dsp_intr),
    .i_enable       (enable),
    .i_clr          (clr),
    .o_intr_pulse   (intr_pulse),
    .o_period       (period),
    .o_period_valid (period_valid),
    .o_intr_count   (intr_count),
    .o_early        (early),
    .o_timeout      (timeout),
    .o_state        (state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (intr_pulse === 1'b1) n_pulse++;
    if (period_valid === 1'b1) n_valid++;
  end

  initial begin
    #2ms;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    since_raise++;
  endtask

  // Waits until gap clocks have elapsed since the previous raise, raises the
  // interrupt and returns in the cycle the pulse is expected.
  task automatic send_edge(input int gap);
    while (since_raise < gap) tick();
    dsp_intr = 1'b1;
    since_raise = 0;
    repeat (LAT) tick();
    dsp_intr = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (intr_pulse !== 1'b0 || period_valid !== 1'b0) begin errors++; $display("FAIL reset_strobes: got %b%b expected 00", intr_pulse, period_valid); end
    checks++; if (period !== 16'd0 || intr_count !== 32'd0) begin errors++; $display("FAIL reset_values: period %0d count %0d expected 0 0", period, intr_count); end
    checks++; if (early !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b expected 00", early, timeout); end
    rst = 1'b0;
    repeat (2) tick();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_disabled: got %0d expected 0", state); end
  endtask

  task automatic test_steady();
    int p0, v0;
    enable = 1'b1;
    tick();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL enter_wait_first: got %0d expected 1", state); end
    p0 = n_pulse; v0 = n_valid;
    // first edge done by hand to pin the latency
    dsp_intr = 1'b1;
    since_raise = 0;
    repeat (LAT - 1) tick();
    checks++; if (intr_pulse !== 1'b0) begin errors++; $display("FAIL latency_early: got %b expected 0", intr_pulse); end
    tick();
    dsp_intr = 1'b0;
    exp_count++;
    checks++; if (intr_pulse !== 1'b1) begin errors++; $display("FAIL latency_pulse: got %b expected 1", intr_pulse); end
    checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL first_no_period: got %b expected 0", period_valid); end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL first_to_run: got %0d expected 2", state); end
    tick();
    checks++; if (intr_pulse !== 1'b0) begin errors++; $display("FAIL pulse_one_cycle: got %b expected 0", intr_pulse); end
    for (int k = 1; k < 10; k++) begin
      send_edge(1000);
      exp_count++;
      checks++; if (intr_pulse !== 1'b1 || period_valid !== 1'b1) begin errors++; $display("FAIL steady_strobe[%0d]: pulse %b valid %b expected 1 1", k, intr_pulse, period_valid); end
      checks++; if (period !== 16'd1000) begin errors++; $display("FAIL steady_period[%0d]: got %0d expected 1000", k, period); end
    end
    tick();
    checks++; if (n_pulse - p0 !== 10) begin errors++; $display("FAIL steady_pulses: got %0d expected 10", n_pulse - p0); end
    checks++; if (n_valid - v0 !== 9) begin errors++; $display("FAIL steady_valids: got %0d expected 9", n_valid - v0); end
    checks++; if (intr_count !== 32'd10) begin errors++; $display("FAIL steady_count: got %0d expected 10", intr_count); end
    checks++; if (early !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL steady_flags: got %b%b expected 00", early, timeout); end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL steady_state: got %0d expected 2", state); end
  endtask

  task automatic test_early();
    send_edge(900);
    exp_count++;
    checks++; if (intr_pulse !== 1'b1 || period_valid !== 1'b1) begin errors++; $display("FAIL early_strobe: pulse %b valid %b expected 1 1", intr_pulse, period_valid); end
    checks++; if (period !== 16'd900) begin errors++; $display("FAIL early_period: got %0d expected 900", period); end
    checks++; if (early !== 1'b1) begin errors++; $display("FAIL early_flag: got %b expected 1", early); end
    checks++; if (intr_count !== exp_count) begin errors++; $display("FAIL early_count: got %0d expected %0d", intr_count, exp_count); end
    tick();
    checks++; if (early !== 1'b1) begin errors++; $display("FAIL early_sticky: got %b expected 1", early); end
    pulse_clr();
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL early_clear: got %b expected 0", early); end
  endtask

  task automatic test_timeout();
    send_edge(1000);
    exp_count++;
    checks++; if (period !== 16'd1000 || early !== 1'b0) begin errors++; $display("FAIL to_pre_edge: period %0d early %b expected 1000 0", period, early); end
    repeat (1999) tick();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_before: got %b expected 0", timeout); end
    tick();
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_at_2000: got %b expected 1", timeout); end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL to_state_run: got %0d expected 2", state); end
    tick();
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL to_state_fault: got %0d expected 3", state); end
    send_edge(0);
    exp_count++;
    checks++; if (intr_pulse !== 1'b1 || period_valid !== 1'b0) begin errors++; $display("FAIL fault_edge: pulse %b valid %b expected 1 0", intr_pulse, period_valid); end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL fault_to_run: got %0d expected 2", state); end
    checks++; if (intr_count !== exp_count) begin errors++; $display("FAIL fault_count: got %0d expected %0d", intr_count, exp_count); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", timeout); end
    pulse_clr();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_clear: got %b expected 0", timeout); end
  endtask

  task automatic test_long_high();
    int p0;
    p0 = n_pulse;
    dsp_intr = 1'b1;
    since_raise = 0;
    repeat (5000) tick();
    dsp_intr = 1'b0;
    repeat (10) tick();
    exp_count++;
    checks++; if (n_pulse - p0 !== 1) begin errors++; $display("FAIL long_high_pulses: got %0d expected 1", n_pulse - p0); end
    checks++; if (intr_count !== exp_count) begin errors++; $display("FAIL long_high_count: got %0d expected %0d", intr_count, exp_count); end
    pulse_clr();
  endtask

  task automatic test_enable_drop();
    int p0;
    send_edge(1000);
    exp_count++;
    checks++; if (period_valid !== 1'b0 || state !== 2'd2) begin errors++; $display("FAIL fault_recover: valid %b state %0d expected 0 2", period_valid, state); end
    send_edge(500);
    exp_count++;
    checks++; if (period !== 16'd500 || early !== 1'b1) begin errors++; $display("FAIL short_period: period %0d early %b expected 500 1", period, early); end
    enable = 1'b0;
    tick();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL disable_idle: got %0d expected 0", state); end
    p0 = n_pulse;
    dsp_intr = 1'b1;
    since_raise = 0;
    repeat (10) tick();
    dsp_intr = 1'b0;
    repeat (10) tick();
    checks++; if (n_pulse - p0 !== 0) begin errors++; $display("FAIL idle_no_pulse: got %0d expected 0", n_pulse - p0); end
    checks++; if (intr_count !== exp_count) begin errors++; $display("FAIL idle_count: got %0d expected %0d", intr_count, exp_count); end
    checks++; if (early !== 1'b1) begin errors++; $display("FAIL idle_flag_kept: got %b expected 1", early); end
    enable = 1'b1;
    tick();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL reenable_wait_first: got %0d expected 1", state); end
    send_edge(20);
    exp_count++;
    checks++; if (intr_pulse !== 1'b1 || period_valid !== 1'b0) begin errors++; $display("FAIL reenable_first: pulse %b valid %b expected 1 0", intr_pulse, period_valid); end
    checks++; if (intr_count !== exp_count) begin errors++; $display("FAIL reenable_count: got %0d expected %0d", intr_count, exp_count); end
    pulse_clr();
  endtask

`ifdef DSP_INTR_GLITCH_FILTER_EN
  task automatic test_glitch_filter();
    int p0;
    p0 = n_pulse;
    dsp_intr = 1'b1;
    since_raise = 0;
    repeat (3) tick();
    dsp_intr = 1'b0;
    repeat (20) tick();
    checks++; if (n_pulse - p0 !== 0) begin errors++; $display("FAIL glitch_3: got %0d expected 0", n_pulse - p0); end
    dsp_intr = 1'b1;
    since_raise = 0;
    repeat (4) tick();
    dsp_intr = 1'b0;
    repeat (20) tick();
    exp_count++;
    checks++; if (n_pulse - p0 !== 1) begin errors++; $display("FAIL glitch_4: got %0d expected 1", n_pulse - p0); end
    pulse_clr();
  endtask
`endif

  task automatic test_clr_vs_timeout();
    send_edge(1000);
    exp_count++;
    repeat (1999) tick();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL clr_to_before: got %b expected 0", timeout); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL clr_vs_set: got %b expected 1", timeout); end
    checks++; if (intr_count !== exp_count) begin errors++; $display("FAIL clr_to_count: got %0d expected %0d", intr_count, exp_count); end
  endtask

  task automatic test_reset_mid();
    send_edge(0);
    dsp_intr = 1'b1;
    since_raise = 0;
    repeat (LAT - 1) tick();
    rst = 1'b1;
    #1;
    checks++; if (state !== 2'd0 || intr_count !== 32'd0 || period !== 16'd0) begin errors++; $display("FAIL rst_mid_values: state %0d count %0d period %0d expected 0 0 0", state, intr_count, period); end
    checks++; if (early !== 1'b0 || timeout !== 1'b0 || period_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_flags: %b%b%b expected 000", early, timeout, period_valid); end
    repeat (3) tick();
    checks++; if (intr_pulse !== 1'b0) begin errors++; $display("FAIL rst_pulse_dropped: got %b expected 0", intr_pulse); end
    dsp_intr = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_steady();
    test_early();
    test_timeout();
    test_long_high();
    test_enable_drop();
`ifdef DSP_INTR_GLITCH_FILTER_EN
    test_glitch_filter();
`endif
    test_clr_vs_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
